cp0_reg: RTL and testbench

// - Coprocessor-0 register file for the exception path: Count, Compare, Status, Cause, EPC, PRId, Config.
// - Latches exception state committed by the MEM stage and raises the timer interrupt.
// - Supplies epc_o to the pipeline controller, which uses it as the ERET target.
// - Supplies status_o/cause_o to the MEM-stage exception detector.

---
 rtl/cp0_reg.sv | 119 +++++++++++
 tb/tb_cp0_reg.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cp0_reg.sv
// cp0_reg: coprocessor-0 register file (Count/Compare/Status/Cause/EPC/PRId/Config) for the exception path
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   we_i, waddr_i, data_i      mtc0 write port
//   raddr_i, data_o            mfc0 read port (combinational, no write bypass)
//   int_i                      external interrupt lines, sampled into Cause.IP[7:2]
//   exception_i                committed exception type from MEM (0 = none)
//   current_inst_addr_i        PC of the excepting instruction
//   is_in_delayslot_i          excepting instruction sits in a delay slot
//   count_o .. prid_o          register values
//   timer_int_o                timer interrupt request
module cp0_reg #(
    parameter logic [31:0] PRID_VAL   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000,
    parameter logic [31:0] STATUS_RST = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] exception_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_INV  = 32'ha;
    localparam logic [31:0] EXC_TRAP = 32'hd;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_ERET = 32'he;
    logic [31:0] count_q, count_d, compare_q, compare_d, status_q, status_d;
    logic [31:0] cause_q, cause_d, epc_q, epc_d;
    logic        timer_q, timer_d;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc, exc_hit;
    logic [4:0]  exc_code;
    assign wr_count   = we_i && waddr_i == 5'd9;
    assign wr_compare = we_i && waddr_i == 5'd11;
    assign wr_status  = we_i && waddr_i == 5'd12;
    assign wr_cause   = we_i && waddr_i == 5'd13;
    assign wr_epc     = we_i && waddr_i == 5'd14;
    assign exc_hit = exception_i == EXC_INT || exception_i == EXC_SYS || exception_i == EXC_INV ||
                     exception_i == EXC_TRAP || exception_i == EXC_OV;
    assign exc_code = exception_i == EXC_INT  ? 5'd0  :
                      exception_i == EXC_SYS  ? 5'd8  :
                      exception_i == EXC_INV  ? 5'd10 :
                      exception_i == EXC_TRAP ? 5'd13 : 5'd12;
    // Writes are applied first; exception fields are then laid over them so they win collisions.
    always_comb begin
        count_d   = wr_count ? data_i : count_q + 32'd1;
        compare_d = wr_compare ? data_i : compare_q;
        timer_d   = wr_compare ? 1'b0 : (compare_q != 32'd0 && count_q == compare_q) ? 1'b1 : timer_q;
        status_d  = wr_status ? data_i : status_q;
        epc_d     = wr_epc ? data_i : epc_q;
        cause_d   = cause_q;
        cause_d[15:10] = int_i;
        cause_d[9:8]   = wr_cause ? data_i[9:8] : cause_q[9:8];
        cause_d[23:22] = wr_cause ? data_i[23:22] : cause_q[23:22];
        if (exc_hit) begin
            status_d[1]  = 1'b1;
            cause_d[6:2] = exc_code;
            // Nested exceptions keep the original return point.
            if (!status_q[1]) begin
                epc_d       = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
                cause_d[31] = is_in_delayslot_i;
            end
        end else if (exception_i == EXC_ERET) begin
            status_d[1] = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            status_q  <= STATUS_RST;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            timer_q   <= timer_d;
        end
    end
    always_comb begin
        case (raddr_i)
            5'd9:    data_o = count_q;
            5'd11:   data_o = compare_q;
            5'd12:   data_o = status_q;
            5'd13:   data_o = cause_q;
            5'd14:   data_o = epc_q;
            5'd15:   data_o = PRID_VAL;
            5'd16:   data_o = CONFIG_VAL;
            default: data_o = 32'd0;
        endcase
    end
    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign config_o    = CONFIG_VAL;
    assign prid_o      = PRID_VAL;
    assign timer_int_o = timer_q;
endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: vector table plus scoreboard checks for cp0_reg, with hand sequences for timer and wrap
module tb_cp0_reg;
    localparam logic [31:0] E_INT  = 32'h1;
    localparam logic [31:0] E_SYS  = 32'h8;
    localparam logic [31:0] E_INV  = 32'ha;
    localparam logic [31:0] E_TRAP = 32'hd;
    localparam logic [31:0] E_OV   = 32'hc;
    localparam logic [31:0] E_ERET = 32'he;
    localparam logic [31:0] E_BAD  = 32'h7;
    logic        clk = 1'b0;
    logic        rst, we_i, is_in_delayslot_i, timer_int_o;
    logic [4:0]  waddr_i, raddr_i;
    logic [5:0]  int_i;
    logic [31:0] data_i, exception_i, current_inst_addr_i, data_o;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [5:0]  irq;
        logic [31:0] exc;
        logic [31:0] pc;
        logic        dly;
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] ep;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl[18];
    vec_t sb[$];
    vec_t e;
    cp0_reg dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i), .raddr_i(raddr_i),
        .int_i(int_i), .exception_i(exception_i), .current_inst_addr_i(current_inst_addr_i),
        .is_in_delayslot_i(is_in_delayslot_i), .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
        .timer_int_o(timer_int_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        rst = 1'b0; we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; raddr_i = 5'd0; int_i = 6'd0;
        exception_i = 32'd0; current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0;
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        we_i = 1'b1; waddr_i = a; data_i = d;
        step();
    endtask
    initial begin
        //           rst   we    wa     wd            ra     irq   exc     pc            dly   status        cause         epc           data_o
        tbl[0]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd15, 6'd0, 32'h0,  32'h0,        1'b0, 32'h10000000, 32'h00000000, 32'h00000000, 32'h004C0102};
        tbl[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd16, 6'd0, 32'h0,  32'h0,        1'b0, 32'h10000000, 32'h00000000, 32'h00000000, 32'h00008000};
        tbl[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd14, 6'd0, E_SYS,  32'h104,      1'b1, 32'h10000002, 32'h80000020, 32'h00000100, 32'h00000100};
        tbl[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd13, 6'd0, E_OV,   32'h200,      1'b0, 32'h10000002, 32'h80000030, 32'h00000100, 32'h80000030};
        tbl[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd12, 6'd0, E_ERET, 32'h0,        1'b0, 32'h10000000, 32'h80000030, 32'h00000100, 32'h10000000};
        tbl[5]  = '{1'b0, 1'b1, 5'd14, 32'hDEAD,     5'd14, 6'd0, E_TRAP, 32'h300,      1'b0, 32'h10000002, 32'h00000034, 32'h00000300, 32'h00000300};
        tbl[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd14, 6'd0, E_ERET, 32'h0,        1'b0, 32'h10000000, 32'h00000034, 32'h00000300, 32'h00000300};
        tbl[7]  = '{1'b0, 1'b1, 5'd13, 32'hFFFFFFFF, 5'd13, 6'd0, 32'h0,  32'h0,        1'b0, 32'h10000000, 32'h00C00334, 32'h00000300, 32'h00C00334};
        tbl[8]  = '{1'b0, 1'b1, 5'd13, 32'h0,        5'd13, 6'd0, 32'h0,  32'h0,        1'b0, 32'h10000000, 32'h00000034, 32'h00000300, 32'h00000034};
        tbl[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd13, 6'd1, 32'h0,  32'h0,        1'b0, 32'h10000000, 32'h00000434, 32'h00000300, 32'h00000434};
        tbl[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  6'd0, 32'h0,  32'h0,        1'b0, 32'h10000000, 32'h00000034, 32'h00000300, 32'h00000000};
        tbl[11] = '{1'b0, 1'b1, 5'd12, 32'h0000FF01, 5'd12, 6'd0, 32'h0,  32'h0,        1'b0, 32'h0000FF01, 32'h00000034, 32'h00000300, 32'h0000FF01};
        tbl[12] = '{1'b0, 1'b1, 5'd12, 32'h12345670, 5'd12, 6'd0, E_INT,  32'h400,      1'b0, 32'h12345672, 32'h00000000, 32'h00000400, 32'h12345672};
        tbl[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd14, 6'd0, E_INV,  32'h500,      1'b1, 32'h12345672, 32'h00000028, 32'h00000400, 32'h00000400};
        tbl[14] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd12, 6'd0, E_BAD,  32'h700,      1'b1, 32'h12345672, 32'h00000028, 32'h00000400, 32'h12345672};
        tbl[15] = '{1'b0, 1'b1, 5'd15, 32'h0,        5'd15, 6'd0, 32'h0,  32'h0,        1'b0, 32'h12345672, 32'h00000028, 32'h00000400, 32'h004C0102};
        tbl[16] = '{1'b0, 1'b1, 5'd14, 32'h1234,     5'd14, 6'd0, 32'h0,  32'h0,        1'b0, 32'h12345672, 32'h00000028, 32'h00001234, 32'h00001234};
        tbl[17] = '{1'b1, 1'b1, 5'd14, 32'h5555,     5'd14, 6'd3, E_SYS,  32'h600,      1'b1, 32'h10000000, 32'h00000000, 32'h00000000, 32'h00000000};
        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_count", count_o, 32'h0);
        chk("rst_compare", compare_o, 32'h0);
        chk("rst_status", status_o, 32'h10000000);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_config", config_o, 32'h00008000);
        chk("rst_prid", prid_o, 32'h004C0102);
        chk("rst_timer", {31'd0, timer_int_o}, 32'h0);
        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; we_i = tbl[i].we; waddr_i = tbl[i].wa; data_i = tbl[i].wd;
            raddr_i = tbl[i].ra; int_i = tbl[i].irq; exception_i = tbl[i].exc;
            current_inst_addr_i = tbl[i].pc; is_in_delayslot_i = tbl[i].dly;
            sb.push_back(tbl[i]);
            step();
            e = sb.pop_front();
            chk($sformatf("v%0d_status", i), status_o, e.st);
            chk($sformatf("v%0d_cause", i), cause_o, e.ca);
            chk($sformatf("v%0d_epc", i), epc_o, e.ep);
            chk($sformatf("v%0d_data", i), data_o, e.rd);
        end
        wr(5'd9, 32'd0);
        chk("tmr_count0", count_o, 32'd0);
        wr(5'd11, 32'd5);
        chk("tmr_compare", compare_o, 32'd5);
        chk("tmr_count1", count_o, 32'd1);
        idle();
        for (int i = 0; i < 20 && count_o != 32'd5; i++) begin
            chk("tmr_early", {31'd0, timer_int_o}, 32'd0);
            step();
        end
        chk("tmr_reach5", count_o, 32'd5);
        chk("tmr_at5", {31'd0, timer_int_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tmr_hold", {31'd0, timer_int_o}, 32'd1);
        end
        wr(5'd11, 32'h100);
        chk("tmr_clr", {31'd0, timer_int_o}, 32'd0);
        chk("tmr_cmp100", compare_o, 32'h100);
        idle();
        raddr_i = 5'd11;
        step();
        chk("tmr_stay0", {31'd0, timer_int_o}, 32'd0);
        chk("rd_compare", data_o, 32'h100);
        wr(5'd9, 32'hFFFFFFFF);
        chk("wrap_max", count_o, 32'hFFFFFFFF);
        idle();
        raddr_i = 5'd9;
        step();
        chk("wrap_zero", count_o, 32'd0);
        chk("rd_count", data_o, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
